pll_reset_seq: RTL and testbench

Power-up and lock-supervision sequencer for the iCE40 system PLL. Runs on the raw board oscillator, pulses the PLL's active-low reset, qualifies the asynchronous LOCK output, and releases the system reset only after lock has been stable for a programmable time. Any later loss of lock re-asserts system reset. With the restart feature compiled in, the PLL is reset again if lock does not arrive within a timeout.

---
 rtl/pll_seq_pkg.sv | 25 ++
 rtl/pll_reset_seq_sync2.sv | 25 ++
 rtl/pll_reset_seq.sv | 163 ++++++++++++++++
 tb/tb_pll_reset_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Holds the sequencer state encoding (also shown on debug LEDs),
// the counter-width helper and the relock counter width.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } seq_state_t;

  localparam int RELOCK_W = 8;

  // Bits needed to hold a down-count that starts at max_count-1.
  function automatic int cnt_width(input int unsigned max_count);
    return (max_count < 32'd2) ? 1 : $clog2(max_count);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
// Both flops clear to 0, so a synchronized "lock" reads low out of reset.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  // First flop may go metastable; second flop gives it a cycle to settle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// Power-up and lock-supervision sequencer for the iCE40 system PLL.
// Runs on the raw board oscillator, pulses PLL RESETB, qualifies the
// synchronized LOCK and releases sys_resetn once lock has been stable
// for LOCK_STABLE_CYCLES plus RST_HOLD_CYCLES. Loss of lock in RUN drops
// sys_resetn again and bumps a saturating relock counter.
//
// Optional feature macro: PLL_AUTORESTART_EN
//   defined   - PLL_RST state exists; pll_resetb pulses low at reset and
//               whenever WAIT_LOCK lasts LOCK_TIMEOUT_CYCLES without lock.
//   undefined - pll_resetb is tied high, reset state is WAIT_LOCK and
//               WAIT_LOCK waits indefinitely.
//
// Every timed state lasts exactly its parameter in cycles: the shared
// down-counter is loaded with N-1 on entry and the exit happens on the
// edge that sees it at zero. All parameters must be non-zero.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned PLL_RESET_CYCLES    = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pll_locked,
  output logic                pll_resetb,
  output logic                sys_resetn,
  output logic                ready,
  output logic [RELOCK_W-1:0] relock_count,
  output logic [2:0]          state
);

  localparam int unsigned CNT_MAX = max_u(max_u(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES),
                                          max_u(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES));
  localparam int CW = cnt_width(CNT_MAX);

  localparam logic [CW-1:0] LOAD_STABLE  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_HOLD    = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_TIMEOUT = CW'(LOCK_TIMEOUT_CYCLES - 1);

`ifdef PLL_AUTORESTART_EN
  localparam logic [CW-1:0] LOAD_PLLRST = CW'(PLL_RESET_CYCLES - 1);
  localparam seq_state_t    RESET_STATE = PLL_RST;
  localparam logic [CW-1:0] RESET_LOAD  = LOAD_PLLRST;
`else
  localparam seq_state_t    RESET_STATE = WAIT_LOCK;
  localparam logic [CW-1:0] RESET_LOAD  = LOAD_TIMEOUT;
`endif

  seq_state_t          state_q;
  logic [CW-1:0]       cnt_q;
  logic                sys_resetn_q;
  logic                ready_q;
  logic [RELOCK_W-1:0] relock_q;
  logic                lock;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pll_locked),
    .q      (lock)
  );

`ifdef PLL_AUTORESTART_EN
  logic pll_resetb_q;
  assign pll_resetb = pll_resetb_q;
`else
  assign pll_resetb = 1'b1;
`endif

  assign sys_resetn   = sys_resetn_q;
  assign ready        = ready_q;
  assign relock_count = relock_q;
  assign state        = state_q;

  // Sequencer: one shared down-counter times every state, outputs are registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= RESET_STATE;
      cnt_q        <= RESET_LOAD;
      sys_resetn_q <= 1'b0;
      ready_q      <= 1'b0;
      relock_q     <= '0;
`ifdef PLL_AUTORESTART_EN
      pll_resetb_q <= 1'b0;
`endif
    end else begin
      case (state_q)
`ifdef PLL_AUTORESTART_EN
        PLL_RST: begin
          if (cnt_q == '0) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= LOAD_TIMEOUT;
            pll_resetb_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
`endif
        WAIT_LOCK: begin
          if (lock) begin
            state_q <= STABLE;
            cnt_q   <= LOAD_STABLE;
          end
`ifdef PLL_AUTORESTART_EN
          else if (cnt_q == '0) begin
            state_q      <= PLL_RST;
            cnt_q        <= LOAD_PLLRST;
            pll_resetb_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
`endif
        end
        STABLE: begin
          if (!lock) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= LOAD_TIMEOUT;
          end else if (cnt_q == '0) begin
            state_q <= HOLD;
            cnt_q   <= LOAD_HOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        HOLD: begin
          if (!lock) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= LOAD_TIMEOUT;
          end else if (cnt_q == '0) begin
            state_q      <= RUN;
            sys_resetn_q <= 1'b1;
            ready_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RUN: begin
          if (!lock) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= LOAD_TIMEOUT;
            sys_resetn_q <= 1'b0;
            ready_q      <= 1'b0;
            if (relock_q != '1) begin
              relock_q <= relock_q + RELOCK_W'(1);
            end
          end
        end
        default: begin
          state_q      <= RESET_STATE;
          cnt_q        <= RESET_LOAD;
          sys_resetn_q <= 1'b0;
          ready_q      <= 1'b0;
`ifdef PLL_AUTORESTART_EN
          pll_resetb_q <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed testbench for pll_reset_seq (P=4, T=50, S=8, H=3).
// Cycle k means "just after the k-th rising edge following resetn release";
// inputs are driven and outputs sampled on the falling edge.
// Works with or without PLL_AUTORESTART_EN defined.
module tb_pll_reset_seq;
  import pll_seq_pkg::*;

  localparam int P = 4;
  localparam int T = 50;
  localparam int S = 8;
  localparam int H = 3;

`ifdef PLL_AUTORESTART_EN
  localparam bit AUTORESTART = 1'b1;
`else
  localparam bit AUTORESTART = 1'b0;
`endif

  localparam logic [2:0] RST_STATE = AUTORESTART ? 3'(PLL_RST) : 3'(WAIT_LOCK);
  localparam logic       RST_PLLB  = AUTORESTART ? 1'b0 : 1'b1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_resetb;
  logic       sys_resetn;
  logic       ready;
  logic [7:0] relock_count;
  logic [2:0] state;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .LOCK_STABLE_CYCLES  (S),
    .RST_HOLD_CYCLES     (H),
    .PLL_RESET_CYCLES    (P),
    .LOCK_TIMEOUT_CYCLES (T)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pll_locked   (pll_locked),
    .pll_resetb   (pll_resetb),
    .sys_resetn   (sys_resetn),
    .ready        (ready),
    .relock_count (relock_count),
    .state        (state)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds reset for two cycles with lock low and releases it on a falling edge (cycle 0).
  task automatic do_reset();
    resetn = 1'b0;
    pll_locked = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (state !== RST_STATE) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %0d expected %0d", state, RST_STATE);
    end
    tests_run++;
    if (pll_resetb !== RST_PLLB) begin
      tests_failed++;
      $display("[TB] FAIL reset_pll_resetb: got %b expected %b", pll_resetb, RST_PLLB);
    end
    tests_run++;
    if (sys_resetn !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_sys_resetn: got %b expected 0", sys_resetn);
    end
    tests_run++;
    if (ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b expected 0", ready);
    end
    tests_run++;
    if (relock_count !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_relock: got %0d expected 0", relock_count);
    end
  endtask

  // Lock raised at cycle 10: sync at 12, STABLE at 13, HOLD at 21, RUN at 24.
  task automatic test_clean_start();
    logic exp_pllb;
    logic exp_sys;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_pllb = AUTORESTART ? (k >= P) : 1'b1;
      exp_sys  = (k >= 10 + 3 + S + H);
      tests_run++;
      if (pll_resetb !== exp_pllb) begin
        tests_failed++;
        $display("[TB] FAIL clean_pll_resetb@%0d: got %b expected %b", k, pll_resetb, exp_pllb);
      end
      tests_run++;
      if (sys_resetn !== exp_sys || ready !== exp_sys) begin
        tests_failed++;
        $display("[TB] FAIL clean_release@%0d: got sys=%b ready=%b expected %b", k, sys_resetn, ready, exp_sys);
      end
      if (k == 13 || k == 21) begin
        tests_run++;
        if (state !== ((k == 13) ? 3'(STABLE) : 3'(HOLD))) begin
          tests_failed++;
          $display("[TB] FAIL clean_state@%0d: got %0d expected %0d", k, state, (k == 13) ? 2 : 3);
        end
      end
      if (k == 10) pll_locked = 1'b1;
    end
  endtask

  // Lock dropped at cycle 15 for 2 cycles: WAIT_LOCK at 18, STABLE at 20, RUN at 31.
  task automatic test_glitch_stable();
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (k == 18 || k == 20) begin
        tests_run++;
        if (state !== ((k == 18) ? 3'(WAIT_LOCK) : 3'(STABLE))) begin
          tests_failed++;
          $display("[TB] FAIL glitch_state@%0d: got %0d expected %0d", k, state, (k == 18) ? 1 : 2);
        end
      end
      if (k == 30 || k == 31) begin
        tests_run++;
        if (sys_resetn !== (k == 31) || ready !== (k == 31)) begin
          tests_failed++;
          $display("[TB] FAIL glitch_release@%0d: got sys=%b ready=%b expected %b", k, sys_resetn, ready, (k == 31));
        end
      end
      if (k == 10) pll_locked = 1'b1;
      if (k == 15) pll_locked = 1'b0;
      if (k == 17) pll_locked = 1'b1;
    end
  endtask

  // Starts in RUN; lock loss shows on the 3rd edge, re-release 14 edges after lock returns.
  task automatic test_lock_loss_run();
    logic [7:0] exp_cnt;
    pll_locked = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      tests_run++;
      if (sys_resetn !== (e < 3)) begin
        tests_failed++;
        $display("[TB] FAIL loss_sys_resetn@edge%0d: got %b expected %b", e, sys_resetn, (e < 3));
      end
    end
    tests_run++;
    if (ready !== 1'b0 || state !== 3'(WAIT_LOCK)) begin
      tests_failed++;
      $display("[TB] FAIL loss_state: got ready=%b state=%0d expected ready=0 state=1", ready, state);
    end
    tests_run++;
    if (relock_count !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL loss_relock: got %0d expected 1", relock_count);
    end
    pll_locked = 1'b1;
    repeat (13) tick();
    tests_run++;
    if (sys_resetn !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL relock_early: got sys=%b expected 0", sys_resetn);
    end
    tick();
    tests_run++;
    if (sys_resetn !== 1'b1 || ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL relock_release: got sys=%b ready=%b expected 1", sys_resetn, ready);
    end
    for (int n = 2; n <= 300; n++) begin
      pll_locked = 1'b0;
      repeat (3) tick();
      exp_cnt = (n > 255) ? 8'd255 : 8'(n);
      tests_run++;
      if (relock_count !== exp_cnt) begin
        tests_failed++;
        $display("[TB] FAIL relock_count@loss%0d: got %0d expected %0d", n, relock_count, exp_cnt);
      end
      pll_locked = 1'b1;
      repeat (14) tick();
      tests_run++;
      if (ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL relock_ready@loss%0d: got %b expected 1", n, ready);
      end
    end
  endtask

  // Assert resetn between edges; outputs must clear before the next rising edge.
  task automatic test_async_reset_run();
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if (sys_resetn !== 1'b0 || ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_outputs: got sys=%b ready=%b expected 0", sys_resetn, ready);
    end
    tests_run++;
    if (relock_count !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_relock: got %0d expected 0", relock_count);
    end
    tests_run++;
    if (state !== RST_STATE || pll_resetb !== RST_PLLB) begin
      tests_failed++;
      $display("[TB] FAIL async_state: got state=%0d pllb=%b expected state=%0d pllb=%b", state, pll_resetb, RST_STATE, RST_PLLB);
    end
  endtask

  // No lock ever: with restart, pll_resetb is low for P cycles every T+P cycles.
  task automatic test_timeout();
    logic       exp_pllb;
    logic [2:0] exp_state;
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      tick();
      exp_pllb = AUTORESTART ? ((k % (T + P)) >= P) : 1'b1;
      tests_run++;
      if (pll_resetb !== exp_pllb) begin
        tests_failed++;
        $display("[TB] FAIL timeout_pll_resetb@%0d: got %b expected %b", k, pll_resetb, exp_pllb);
      end
      tests_run++;
      if (sys_resetn !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL timeout_sys_resetn@%0d: got %b expected 0", k, sys_resetn);
      end
      if (k == T + P || k == T + 2 * P) begin
        exp_state = (AUTORESTART && k == T + P) ? 3'(PLL_RST) : 3'(WAIT_LOCK);
        tests_run++;
        if (state !== exp_state) begin
          tests_failed++;
          $display("[TB] FAIL timeout_state@%0d: got %0d expected %0d", k, state, exp_state);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_start();
    test_glitch_stable();
    test_lock_loss_run();
    test_async_reset_run();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
